// File: rtl/fe_mul_arbiter.sv
// fe_mul_arbiter: round-robin arbiter that lets NREQ requesters share one
// fe_mulx field multiplier. Requests are one-cycle pulses that are latched
// into a pending vector. One multiply is in flight at a time, and each
// product returns to its winner with a one-cycle done pulse.
module fe_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 320,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_op_a,
  input  logic [NREQ*W-1:0] req_op_b,
  output logic [NREQ-1:0]   req_done,
  output logic [W-1:0]      res,
  output logic [W-1:0]      mul_op_a,
  output logic [W-1:0]      mul_op_b,
  output logic              mul_valid,
  input  logic [W-1:0]      mul_res,
  input  logic              mul_done,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic              proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [W-1:0]    mul_op_a_q, mul_op_a_d;
  logic [W-1:0]    mul_op_b_q, mul_op_b_d;
  logic            mul_valid_q, mul_valid_d;
  logic [W-1:0]    res_q, res_d;
  logic [NREQ-1:0] req_done_q, req_done_d;
  logic            proto_err_q, proto_err_d;

  logic [IDW-1:0]  win_idx;
  logic [W-1:0]    op_a_arr [NREQ];
  logic [W-1:0]    op_b_arr [NREQ];

  // Unpack the flattened operand buses so the winner can be selected by index.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_a_arr[gi] = req_op_a[gi*W +: W];
    assign op_b_arr[gi] = req_op_b[gi*W +: W];
  end

  // A new pulse always sets pending. This also covers a pulse arriving on the
  // same edge as that requester's completion, where the set takes priority.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pending
    assign pending_d[gi] = (pending_q[gi] & ~req_done_d[gi]) | req_valid[gi];
  end

  // Round-robin search: the first pending index at or after rr_ptr, wrapping.
  // The loop scans from the far end back towards rr_ptr, so the nearest match wins.
  always_comb begin
    int s;
    s       = 0;
    win_idx = rr_ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = int'(rr_ptr_q) + k;
      if (s >= NREQ) s = s - NREQ;
      if (pending_q[IDW'(s)]) win_idx = IDW'(s);
    end
  end

  // Next-state and registered-output logic for the issue/complete sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    mul_op_a_d  = mul_op_a_q;
    mul_op_b_d  = mul_op_b_q;
    mul_valid_d = 1'b0;
    res_d       = res_q;
    req_done_d  = '0;
    proto_err_d = proto_err_q | (|(req_valid & pending_q));
    case (state_q)
      IDLE: begin
        // Only requests already latched are eligible; a same-cycle pulse waits.
        if (|pending_q) begin
          grant_id_d  = win_idx;
          mul_op_a_d  = op_a_arr[win_idx];
          mul_op_b_d  = op_b_arr[win_idx];
          mul_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          res_d                  = mul_res;
          req_done_d[grant_id_q] = 1'b1;
          if (grant_id_q == IDW'(NREQ - 1)) rr_ptr_d = '0;
          else                              rr_ptr_d = grant_id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset also drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      mul_op_a_q  <= '0;
      mul_op_b_q  <= '0;
      mul_valid_q <= 1'b0;
      res_q       <= '0;
      req_done_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      mul_op_a_q  <= mul_op_a_d;
      mul_op_b_q  <= mul_op_b_d;
      mul_valid_q <= mul_valid_d;
      res_q       <= res_d;
      req_done_q  <= req_done_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign req_done  = req_done_q;
  assign res       = res_q;
  assign mul_op_a  = mul_op_a_q;
  assign mul_op_b  = mul_op_b_q;
  assign mul_valid = mul_valid_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_id_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// Testbench for fe_mul_arbiter. A behavioural fe_mulx with programmable
// latency answers the issued operations. A cycle-level reference model, built
// from the arbitration rules, predicts every output on every cycle.
module tb_fe_mul_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 320;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_op_a, req_op_b;
  logic [NREQ-1:0]   req_done;
  logic [W-1:0]      res, mul_op_a, mul_op_b, mul_res;
  logic              mul_valid, mul_done, busy, proto_err;
  logic [IDW-1:0]    grant_id;

  always #5 clk = ~clk;

  fe_mul_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op_a(req_op_a),
    .req_op_b(req_op_b), .req_done(req_done), .res(res), .mul_op_a(mul_op_a),
    .mul_op_b(mul_op_b), .mul_valid(mul_valid), .mul_res(mul_res),
    .mul_done(mul_done), .busy(busy), .grant_id(grant_id), .proto_err(proto_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit            m_pend [NREQ];
  int            m_rr, m_cur;
  logic [NREQ-1:0] e_done;
  logic [W-1:0]  e_res, e_opa, e_opb;
  bit            e_mv, e_perr;
  int            e_gid;
  bit            chk_on;

  // fe_mulx behavioural model
  int            mx_cnt = 0;
  int            lat_lo = 2, lat_hi = 2;
  bit            spur_en = 0;
  logic [W-1:0]  mx_prod;

  // Observation log
  int            done_q [$];
  int            done_cnt [NREQ];
  int            mv_cnt;
  logic [W-1:0]  last_res;
  bit            repulse0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] x;
    for (int i = 0; i < W / 32; i++) x[i*32 +: 32] = $urandom();
    return x;
  endfunction

  task automatic clr_log();
    done_q.delete();
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
    mv_cnt = 0;
  endtask

  // Advance the reference model across one clock edge using the inputs now driven.
  task automatic model_step();
    int w;
    int clr;
    bit in_wait;
    w = -1;
    clr = -1;
    if (rst) begin
      for (int i = 0; i < NREQ; i++) m_pend[i] = 0;
      m_rr = 0; m_cur = -1; e_done = '0; e_res = '0; e_opa = '0; e_opb = '0;
      e_mv = 0; e_perr = 0; e_gid = 0;
      return;
    end
    in_wait = (m_cur >= 0) && !e_mv;
    e_done = '0;
    e_mv = 0;
    if (in_wait && mul_done) begin
      e_done[m_cur] = 1'b1;
      e_res = mul_res;
      m_rr = (m_cur + 1) % NREQ;
      clr = m_cur;
      m_cur = -1;
    end else if (m_cur < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_pend[(m_rr + k) % NREQ]) begin
          w = (m_rr + k) % NREQ;
          break;
        end
      end
      if (w >= 0) begin
        m_cur = w; e_gid = w; e_mv = 1;
        e_opa = req_op_a[w*W +: W];
        e_opb = req_op_b[w*W +: W];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && m_pend[i]) e_perr = 1;
      m_pend[i] = (m_pend[i] && (i != clr)) || req_valid[i];
    end
  endtask

  // One clock cycle: check outputs, run fe_mulx, apply inputs, update the model.
  task automatic cyc(input logic [NREQ-1:0] v, input logic r);
    logic [NREQ-1:0] vv;
    vv = v;
    @(negedge clk);
    if (chk_on) begin
      check_val("req_done", req_done, e_done);
      check_val("res", res, e_res);
      check_val("mul_valid", mul_valid, e_mv);
      check_val("mul_op_a", mul_op_a, e_opa);
      check_val("mul_op_b", mul_op_b, e_opb);
      check_val("grant_id", grant_id, e_gid);
      check_val("busy", busy, (m_cur >= 0));
      check_val("proto_err", proto_err, e_perr);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_done[i] === 1'b1) begin
        done_q.push_back(i);
        done_cnt[i]++;
        last_res = res;
        $display("txn done req=%0d res=%0h t=%0t", i, res, $time);
        if (i == 0 && repulse0) begin
          vv[0] = 1'b1;
          repulse0 = 0;
        end
      end
    end
    if (mul_valid === 1'b1) mv_cnt++;
    mul_done = 1'b0;
    if (mx_cnt > 0) begin
      mx_cnt--;
      if (mx_cnt == 0) begin
        mul_done = 1'b1;
        mul_res = mx_prod;
      end
    end else if (spur_en && $urandom_range(15) == 0) begin
      mul_done = 1'b1;
      mul_res = rnd_w();
    end
    if (mul_valid === 1'b1) begin
      mx_prod = mul_op_a * mul_op_b;
      mx_cnt = $urandom_range(lat_hi, lat_lo);
    end
    req_valid = vv;
    rst = r;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0);
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op_a[i*W +: W] = a;
    req_op_b[i*W +: W] = b;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_op_a = '0; req_op_b = '0;
    mul_done = 1'b0; mul_res = '0; mx_prod = '0; last_res = '0;
    repulse0 = 0; chk_on = 0; m_cur = -1;
    clr_log();
    cyc('0, 1'b1);
    chk_on = 1;
    cyc('0, 1'b1);
    idle(2);

    // 1: single request from req1, operands 2 and 3
    clr_log();
    set_ops(1, 320'd2, 320'd3);
    cyc(4'b0010, 1'b0);
    idle(10);
    check_val("t1_cnt", done_cnt[1], 1);
    check_val("t1_res", last_res, 320'd6);

    // 2: all four pulse together straight out of reset
    cyc('0, 1'b1);
    clr_log();
    for (int i = 0; i < NREQ; i++) set_ops(i, rnd_w(), rnd_w());
    cyc(4'b1111, 1'b0);
    idle(30);
    check_val("t2_cnt", done_q.size(), 4);
    for (int k = 0; k < NREQ; k++)
      if (k < done_q.size()) check_val("t2_order", done_q[k], k);
    check_val("t2_mv", mv_cnt, 4);

    // 3: rr_ptr at 2 after serving req1; req0 and req3 together -> req3 first
    cyc('0, 1'b1);
    clr_log();
    set_ops(1, rnd_w(), rnd_w());
    cyc(4'b0010, 1'b0);
    idle(10);
    set_ops(0, rnd_w(), rnd_w());
    set_ops(3, rnd_w(), rnd_w());
    cyc(4'b1001, 1'b0);
    idle(20);
    check_val("t3_cnt", done_q.size(), 3);
    if (done_q.size() == 3) begin
      check_val("t3_first", done_q[1], 3);
      check_val("t3_second", done_q[2], 0);
    end

    // 4: req0 re-pulses on its own req_done cycle
    clr_log();
    set_ops(0, 320'd5, 320'd11);
    repulse0 = 1;
    cyc(4'b0001, 1'b0);
    idle(20);
    check_val("t4_cnt", done_cnt[0], 2);
    check_val("t4_perr", proto_err, 1'b0);

    // 5: req2 pulses twice before completion
    clr_log();
    set_ops(2, rnd_w(), rnd_w());
    cyc(4'b0100, 1'b0);
    cyc('0, 1'b0);
    cyc(4'b0100, 1'b0);
    idle(12);
    check_val("t5_cnt", done_cnt[2], 1);
    check_val("t5_perr", proto_err, 1'b1);
    cyc('0, 1'b1);
    check_val("t5_perr_rst", proto_err, 1'b0);

    // 6: reset while waiting on the multiplier; stale done must be ignored
    clr_log();
    lat_lo = 6; lat_hi = 6;
    set_ops(1, rnd_w(), rnd_w());
    cyc(4'b0010, 1'b0);
    idle(4);
    cyc('0, 1'b1);
    check_val("t6_busy", busy, 1'b0);
    idle(10);
    check_val("t6_nodone", done_q.size(), 0);
    lat_lo = 2; lat_hi = 2;
    set_ops(2, 320'd7, 320'd9);
    cyc(4'b0100, 1'b0);
    idle(10);
    check_val("t6_cnt", done_cnt[2], 1);
    check_val("t6_res", last_res, 320'd63);

    // Randomized traffic with variable latency, stray done pulses and resets
    lat_lo = 1; lat_hi = 4; spur_en = 1;
    for (int c = 0; c < 1500; c++) begin
      logic [NREQ-1:0] v;
      logic r;
      v = '0;
      r = ($urandom_range(299) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!m_pend[i]) begin
          if ($urandom_range(5) == 0) begin
            set_ops(i, rnd_w(), rnd_w());
            v[i] = 1'b1;
          end
        end else if ($urandom_range(79) == 0) begin
          v[i] = 1'b1;
        end
      end
      cyc(v, r);
    end
    spur_en = 0;
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
